int_wb_queue: RTL
=================

Name: int_wb_queue

Overview:
- Write-back initiator for the integer register file.
- Collects result writes from the MEM and ALU stages through valid/ready handshakes and buffers them in an in-order queue.
- Drains exactly one write per cycle onto the register-file write port (address, data, enable).
- Answers two combinational bypass lookups so decode can obtain values that are queued but not yet written.

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- XLEN, 32, data width.
- AW, 5, register address width.

Ports:
- clk_i  in  1  clock, rising edge.
- rsn_i  in  1  reset, asynchronous, active-low.
- mem_valid_i  in  1  MEM result valid.
- mem_addr_i  in  AW  MEM destination register.
- mem_data_i  in  XLEN  MEM result.
- mem_ready_o  out  1  MEM write accepted.
- alu_valid_i  in  1  ALU result valid.
- alu_addr_i  in  AW  ALU destination register.
- alu_data_i  in  XLEN  ALU result.
- alu_ready_o  out  1  ALU write accepted.
- wb_we_o  out  1  register-file write_enable.
- wb_addr_o  out  AW  register-file write_addr.
- wb_data_o  out  XLEN  register-file write_data.
- byp_a_addr_i  in  AW  lookup address A.
- byp_a_hit_o  out  1  A is pending in the queue.
- byp_a_data_o  out  XLEN  youngest pending value for A.
- byp_b_addr_i  in  AW  lookup address B.
- byp_b_hit_o  out  1  B is pending in the queue.
- byp_b_data_o  out  XLEN  youngest pending value for B.
- empty_o  out  1  queue empty.

Behaviour:
- Clock and reset: single clock clk_i; reset rsn_i is asynchronous and active-low.
- Reset state:
  - Read pointer, write pointer and count are 0.
  - wb_we_o=0; wb_addr_o and wb_data_o are driven from an empty head and are don't-care.
  - Both hit outputs are 0; empty_o=1.
  - mem_ready_o=1 and alu_ready_o=1 (free=DEPTH).
  - A reset asserted mid-operation discards all queued entries with no partial write.
- Ready rules (registered count only; no valid-to-ready combinational path):
  - free = DEPTH - count.
  - mem_ready_o = (free >= 1).
  - alu_ready_o = (free >= 2).
- Push rules:
  - A transfer occurs when valid && ready at the rising edge.
  - A transfer with addr==0 is accepted but not stored (x0 writes are discarded).
  - When both transfer in the same cycle, the MEM entry is enqueued first (older), then the ALU entry.
  - 0, 1 or 2 pushes per cycle.
- Drain rules:
  - The register file never stalls; the head is presented combinationally.
  - wb_we_o = !empty; wb_addr_o and wb_data_o come from the head entry.
  - The head is popped on every edge where wb_we_o=1.
- Count update: count_next = count + pushes - pop.
- Latency: a write accepted at edge k is driven on the write port during cycle k+1 when the queue was empty, and is committed to the register file at edge k+1.
- Pointers: wrap modulo DEPTH; count is a separate register of width log2(DEPTH)+1.
- Bypass:
  - Search every valid entry for an address match with the lookup address.
  - The youngest match wins, i.e. the highest age relative to the read pointer.
  - byp_x_hit_o = 1 on a match; byp_x_data_o = matching data, otherwise 0.
  - Lookup address 0 never hits.
  - The head entry being written this cycle still counts as a hit.
  - Entries in flight on the push ports in the same cycle are not searched.
- Boundaries:
  - Full (count=DEPTH): both ready outputs are 0; the pop still proceeds.
  - count=DEPTH-1: mem_ready_o=1, alu_ready_o=0.
  - Empty: wb_we_o=0, no pop.
  - A push and a pop in the same cycle at count=1 leaves count=1.
  - A push and a pop to the same slot index are impossible, because pushes only target free slots.
- Ordering: register-file writes occur in exact acceptance order, so a later write to the same register always overwrites an earlier one.

Decomposition:
- Shared package int_pkg:
  - XLEN and AW constants.
  - Typedef wb_entry_t: valid, addr, data.
  - Constant REG_ZERO = 5'd0.
- One natural sub-module, int_wb_match: a combinational youngest-match search over the entry array, given read pointer, count and lookup address. It is instantiated twice (A and B).

Test Plan:
- Reset: rsn_i low mid-stream with 3 entries queued -> immediately wb_we_o=0, empty_o=1, both ready=1; after release, no stale write ever appears.
- Single write: mem writes x5=0x1234 at edge k -> cycle k+1 shows wb_we_o=1, wb_addr_o=5, wb_data_o=0x1234; empty_o=1 after edge k+1.
- Dual push ordering: mem x3=0xA and alu x3=0xB in the same cycle -> two consecutive writes, 0xA then 0xB; byp_a_addr_i=3 returns 0xB with hit while both are queued.
- x0 discard: alu writes x0=0xFFFF_FFFF -> alu_ready_o=1, no write-port activity, byp lookup of 0 gives hit=0.
- Fill and backpressure: both ports push continuously from empty (DEPTH=4) -> count steps 0,2,3,3... with alu_ready_o dropping at count>=3 and mem_ready_o never 0; the write sequence exactly matches acceptance order.
- Pointer wrap: issue 10 alternating single pushes with addresses 1..10 -> all writes appear in order with correct data, confirming pointer wrap.

Source files
------------

// File: rtl/int_pkg.sv
// Shared types and constants for the integer write-back path.
package int_pkg;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic            valid;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/int_wb_match.sv
// Youngest-match search over the write-back queue, used for decode bypass.
module int_wb_match
    import int_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wb_entry_t [DEPTH-1:0]      entries,
    input  logic [$clog2(DEPTH)-1:0]   rptr,
    input  logic [$clog2(DEPTH):0]     count,
    input  logic [AW-1:0]              addr,
    output logic                       hit,
    output logic [XLEN-1:0]            data
);
    localparam int PW = $clog2(DEPTH);

    // Walk from oldest to youngest so the last match found is the youngest.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int age = 0; age < DEPTH; age++) begin
            if (((PW+1)'(age) < count)
                && entries[rptr + PW'(age)].valid
                && (entries[rptr + PW'(age)].addr == addr)
                && (addr != REG_ZERO)) begin
                hit  = 1'b1;
                data = entries[rptr + PW'(age)].data;
            end
        end
    end
endmodule

// File: rtl/int_wb_queue.sv
// In-order write-back queue: accepts MEM/ALU results, drains one register-file
// write per cycle, and serves two bypass lookups over the pending entries.
module int_wb_queue
    import int_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = int_pkg::XLEN,
    parameter int AW    = int_pkg::AW
) (
    input  logic            clk_i,
    input  logic            rsn_i,
    input  logic            mem_valid_i,
    input  logic [AW-1:0]   mem_addr_i,
    input  logic [XLEN-1:0] mem_data_i,
    output logic            mem_ready_o,
    input  logic            alu_valid_i,
    input  logic [AW-1:0]   alu_addr_i,
    input  logic [XLEN-1:0] alu_data_i,
    output logic            alu_ready_o,
    output logic            wb_we_o,
    output logic [AW-1:0]   wb_addr_o,
    output logic [XLEN-1:0] wb_data_o,
    input  logic [AW-1:0]   byp_a_addr_i,
    output logic            byp_a_hit_o,
    output logic [XLEN-1:0] byp_a_data_o,
    input  logic [AW-1:0]   byp_b_addr_i,
    output logic            byp_b_hit_o,
    output logic [XLEN-1:0] byp_b_data_o,
    output logic            empty_o
);
    localparam int PW = $clog2(DEPTH);

    wb_entry_t [DEPTH-1:0] entries;
    logic [PW-1:0]         rptr, wptr, alu_slot;
    logic [PW:0]           count;
    logic                  mem_push, alu_push, pop;

    // Readiness depends only on registered occupancy, never on valid.
    assign mem_ready_o = count <= (PW+1)'(DEPTH - 1);
    assign alu_ready_o = count <= (PW+1)'(DEPTH - 2);
    assign empty_o     = count == '0;

    assign pop       = !empty_o;
    assign wb_we_o   = pop;
    assign wb_addr_o = entries[rptr].addr;
    assign wb_data_o = entries[rptr].data;

    // x0 transfers complete the handshake but are dropped.
    assign mem_push = mem_valid_i && mem_ready_o && (mem_addr_i != REG_ZERO);
    assign alu_push = alu_valid_i && alu_ready_o && (alu_addr_i != REG_ZERO);
    assign alu_slot = wptr + PW'(mem_push);

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            entries <= '0;
            rptr    <= '0;
            wptr    <= '0;
            count   <= '0;
        end else begin
            if (pop) begin
                entries[rptr].valid <= 1'b0;
                rptr                <= rptr + PW'(1);
            end
            if (mem_push)
                entries[wptr] <= '{valid: 1'b1, addr: mem_addr_i, data: mem_data_i};
            if (alu_push)
                entries[alu_slot] <= '{valid: 1'b1, addr: alu_addr_i, data: alu_data_i};
            wptr  <= wptr + PW'(mem_push) + PW'(alu_push);
            count <= count + (PW+1)'(mem_push) + (PW+1)'(alu_push) - (PW+1)'(pop);
        end
    end

    int_wb_match #(.DEPTH(DEPTH)) u_match_a (
        .entries (entries),
        .rptr    (rptr),
        .count   (count),
        .addr    (byp_a_addr_i),
        .hit     (byp_a_hit_o),
        .data    (byp_a_data_o)
    );

    int_wb_match #(.DEPTH(DEPTH)) u_match_b (
        .entries (entries),
        .rptr    (rptr),
        .count   (count),
        .addr    (byp_b_addr_i),
        .hit     (byp_b_hit_o),
        .data    (byp_b_data_o)
    );
endmodule
